sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Shares one sram_driver instance between two requesters: port A (serial command handler) and port B (bulk fill/dump engine).
- Accepts one read or write per grant and forwards it to the driver as a one-cycle start pulse.
- Tracks the driver's ready handshake and returns read data with a completion pulse to the granted requester.
- Sits between the serial control logic in top and sram_driver; replaces direct ram_start/ram_re driving.

Parameters:
- ADDR_W, 13, SRAM address width.
- BUSY_WAIT, 4, max cycles to wait in WAIT_BUSY for drv_ready to fall before treating the access as complete.
- TIMEOUT, 255, max cycles in WAIT_DONE (used only with SRAM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- a_req  in  1  port A request; held high with fields stable until a_ack
- a_re  in  1  port A: 1 = read, 0 = write
- a_addr  in  ADDR_W  port A address
- a_wdata  in  8  port A write data
- a_ack  out  1  one-cycle completion pulse to A
- a_rdata  out  8  last read data returned to A
- b_req, b_re, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B
- drv_ready  in  1  sram_driver ready
- drv_data_read  in  8  sram_driver read data
- drv_start  out  1  one-cycle start to driver
- drv_re  out  1  read enable to driver
- drv_address  out  ADDR_W  address to driver
- drv_data_write  out  8  write data to driver
- busy  out  1  high whenever state is not IDLE
- grant_b  out  1  0 = A owns current/last access, 1 = B
- timeout_err  out  1  sticky error flag (SRAM_ARB_TIMEOUT_EN only)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high; it is sampled on posedge clk only.
- Reset values:
  - State IDLE.
  - drv_start, drv_re, a_ack, b_ack, busy, timeout_err = 0.
  - drv_address, drv_data_write, a_rdata, b_rdata = 0.
  - grant_b = 1, so A wins the first contention.
- IDLE:
  - If drv_ready = 1 and a request is pending, choose a winner.
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins (round-robin): grant_b <= ~grant_b.
  - Latch the winner's re/addr/wdata into drv_re/drv_address/drv_data_write, then go to ISSUE.
  - If drv_ready = 0, stay in IDLE.
- ISSUE:
  - Assert drv_start for exactly this one cycle, then go to WAIT_BUSY.
  - drv_re, drv_address and drv_data_write stay stable from ISSUE until RESP.
- WAIT_BUSY:
  - On drv_ready = 0, go to WAIT_DONE.
  - If drv_ready stays 1 for BUSY_WAIT cycles, go to RESP; this covers a driver that completes without visibly dropping ready.
- WAIT_DONE:
  - On drv_ready = 1, go to RESP.
- RESP:
  - Pulse ack of the granted port for one cycle.
  - If the access was a read, capture drv_data_read into that port's rdata. The other port's rdata is unchanged; writes leave rdata unchanged.
  - Return to IDLE.
- Latency, uncontended, driver at WAIT_TIME = N: req seen in IDLE -> ack roughly N + 5 cycles later. The bench checks ack arrives at most N + 8 cycles after req.
- Back-to-back traffic:
  - A requester that drops req the cycle after ack and re-raises it is legal.
  - A req still high in the IDLE cycle after ack is treated as a new request.
  - Requesters must deassert req on the cycle ack is seen.
- Simultaneous events:
  - A request arriving while busy is held off; no ack is given until it is granted.
  - With both ports continuously requesting, grants strictly alternate.
- Dropping req:
  - Dropping req before ack is illegal, and the arbiter ignores it.
  - The granted access completes and ack is still pulsed.
- Reset mid-operation:
  - Return to IDLE immediately and clear all outputs to their reset values.
  - Any access in flight is abandoned with no ack.
  - The driver is reset by the same reset.

Optional Feature:
- Macro: SRAM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in WAIT_DONE.
  - If TIMEOUT cycles pass with drv_ready = 0, set timeout_err (sticky until reset).
  - Go to RESP and ack the granted port; on a read, rdata is loaded with 8'hFF.
- Without the macro:
  - No counter; WAIT_DONE waits indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- Single write:
  - Stimulus: A write addr 0x0010, data 0xA5, driver model WAIT_TIME = 20.
  - Required: exactly one drv_start pulse with drv_re = 0, drv_address = 0x0010, drv_data_write = 0xA5; one a_ack; b_ack never pulses.
- Read after write:
  - Stimulus: B reads 0x0010 with the model returning 0xA5.
  - Required: b_ack pulses; b_rdata = 0xA5; a_rdata unchanged.
- Contention:
  - Stimulus: a_req and b_req raised on the same cycle, 4 requests each.
  - Required: grant order A, B, A, B, A, B, A, B; 8 drv_start pulses; no overlapping accesses.
- Busy hold-off:
  - Stimulus: b_req raised while A's access is in WAIT_DONE.
  - Required: drv_start is not reasserted until a_ack has pulsed and IDLE is re-entered.
- Reset mid-access:
  - Stimulus: reset asserted for 1 cycle in WAIT_DONE.
  - Required: next cycle busy = 0, drv_start = 0, no ack; a fresh A request then completes normally with A granted.
- Timeout (SRAM_ARB_TIMEOUT_EN):
  - Stimulus: driver model holds drv_ready = 0 forever on an A read.
  - Required: after 255 cycles, a_ack pulses, a_rdata = 0xFF, timeout_err = 1 and stays 1 until reset.

Source files
------------

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Shares one sram_driver between port A (serial command handler)
//            and port B (bulk fill/dump engine). One read or write is taken
//            per grant, issued to the driver as a one-cycle start pulse, and
//            completed with a one-cycle ack (plus read data) to the winner.
//            Contention is resolved round-robin; A wins the first contention.
// Ports    : clk, reset (sync, active-high)
//            a_req/a_re/a_addr/a_wdata -> a_ack/a_rdata   requester A
//            b_req/b_re/b_addr/b_wdata -> b_ack/b_rdata   requester B
//            drv_ready/drv_data_read   -> drv_start/drv_re/drv_address/
//                                         drv_data_write  sram_driver side
//            busy, grant_b, timeout_err                   status
// Options  : SRAM_ARB_TIMEOUT_EN - bounds WAIT_DONE to TIMEOUT cycles; on
//            expiry timeout_err is set (sticky) and a read returns 8'hFF.
//            Without it WAIT_DONE waits indefinitely and timeout_err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int BUSY_WAIT = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_re,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_ack,
    output logic [7:0]        a_rdata,
    input  logic              b_req,
    input  logic              b_re,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_ack,
    output logic [7:0]        b_rdata,
    input  logic              drv_ready,
    input  logic [7:0]        drv_data_read,
    output logic              drv_start,
    output logic              drv_re,
    output logic [ADDR_W-1:0] drv_address,
    output logic [7:0]        drv_data_write,
    output logic              busy,
    output logic              grant_b,
    output logic              timeout_err
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_ISSUE     = 3'd1;
    localparam logic [2:0] c_ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_ST_RESP      = 3'd4;

    // One counter serves both the BUSY_WAIT and TIMEOUT windows.
    localparam int c_CNT_MAX = (TIMEOUT > BUSY_WAIT) ? TIMEOUT : BUSY_WAIT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    logic [2:0]         r_state,          w_state;
    logic [c_CNT_W-1:0] r_cnt,            w_cnt;
    logic               r_drv_start,      w_drv_start;
    logic               r_drv_re,         w_drv_re;
    logic [ADDR_W-1:0]  r_drv_address,    w_drv_address;
    logic [7:0]         r_drv_data_write, w_drv_data_write;
    logic               r_a_ack,          w_a_ack;
    logic               r_b_ack,          w_b_ack;
    logic [7:0]         r_a_rdata,        w_a_rdata;
    logic [7:0]         r_b_rdata,        w_b_rdata;
    logic               r_busy,           w_busy;
    logic               r_grant_b,        w_grant_b;
    logic               r_timeout_err,    w_timeout_err;
    logic               w_pick_b;
    logic               w_resp;
    logic [7:0]         w_resp_data;

    always_comb begin
        w_state          = r_state;
        w_cnt            = r_cnt;
        w_drv_start      = 1'b0;
        w_drv_re         = r_drv_re;
        w_drv_address    = r_drv_address;
        w_drv_data_write = r_drv_data_write;
        w_a_ack          = 1'b0;
        w_b_ack          = 1'b0;
        w_a_rdata        = r_a_rdata;
        w_b_rdata        = r_b_rdata;
        w_grant_b        = r_grant_b;
        w_timeout_err    = r_timeout_err;
        w_pick_b         = 1'b0;
        w_resp           = 1'b0;
        w_resp_data      = drv_data_read;

        case (r_state)
            c_ST_IDLE: begin
                if (drv_ready && (a_req || b_req)) begin
                    // B wins when alone, or when both ask and A went last.
                    w_pick_b         = b_req && (!a_req || !r_grant_b);
                    w_grant_b        = w_pick_b;
                    w_drv_re         = w_pick_b ? b_re    : a_re;
                    w_drv_address    = w_pick_b ? b_addr  : a_addr;
                    w_drv_data_write = w_pick_b ? b_wdata : a_wdata;
                    // Registered start is high exactly during ISSUE.
                    w_drv_start      = 1'b1;
                    w_state          = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_cnt   = '0;
                w_state = c_ST_WAIT_BUSY;
            end
            c_ST_WAIT_BUSY: begin
                if (!drv_ready) begin
                    w_cnt   = '0;
                    w_state = c_ST_WAIT_DONE;
                end else if (r_cnt == c_CNT_W'(BUSY_WAIT - 1)) begin
                    // Driver finished without a visible ready drop.
                    w_resp = 1'b1;
                end else begin
                    w_cnt = r_cnt + c_CNT_W'(1);
                end
            end
            c_ST_WAIT_DONE: begin
                if (drv_ready) begin
                    w_resp = 1'b1;
`ifdef SRAM_ARB_TIMEOUT_EN
                end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                    w_resp        = 1'b1;
                    w_resp_data   = 8'hFF;
                    w_timeout_err = 1'b1;
                end else begin
                    w_cnt = r_cnt + c_CNT_W'(1);
`endif
                end
            end
            c_ST_RESP: begin
                w_state = c_ST_IDLE;
            end
            default: begin
                w_state = c_ST_IDLE;
            end
        endcase

        // Ack and read data are registered together so rdata is valid
        // in the same cycle the requester sees its ack.
        if (w_resp) begin
            w_state = c_ST_RESP;
            if (r_grant_b) begin
                w_b_ack = 1'b1;
                if (r_drv_re) w_b_rdata = w_resp_data;
            end else begin
                w_a_ack = 1'b1;
                if (r_drv_re) w_a_rdata = w_resp_data;
            end
        end

        w_busy = (w_state != c_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_ST_IDLE;
            r_cnt            <= '0;
            r_drv_start      <= 1'b0;
            r_drv_re         <= 1'b0;
            r_drv_address    <= '0;
            r_drv_data_write <= 8'h00;
            r_a_ack          <= 1'b0;
            r_b_ack          <= 1'b0;
            r_a_rdata        <= 8'h00;
            r_b_rdata        <= 8'h00;
            r_busy           <= 1'b0;
            r_grant_b        <= 1'b1;
            r_timeout_err    <= 1'b0;
        end else begin
            r_state          <= w_state;
            r_cnt            <= w_cnt;
            r_drv_start      <= w_drv_start;
            r_drv_re         <= w_drv_re;
            r_drv_address    <= w_drv_address;
            r_drv_data_write <= w_drv_data_write;
            r_a_ack          <= w_a_ack;
            r_b_ack          <= w_b_ack;
            r_a_rdata        <= w_a_rdata;
            r_b_rdata        <= w_b_rdata;
            r_busy           <= w_busy;
            r_grant_b        <= w_grant_b;
            r_timeout_err    <= w_timeout_err;
        end
    end

    assign drv_start      = r_drv_start;
    assign drv_re         = r_drv_re;
    assign drv_address    = r_drv_address;
    assign drv_data_write = r_drv_data_write;
    assign a_ack          = r_a_ack;
    assign b_ack          = r_b_ack;
    assign a_rdata        = r_a_rdata;
    assign b_rdata        = r_b_rdata;
    assign busy           = r_busy;
    assign grant_b        = r_grant_b;
    assign timeout_err    = r_timeout_err;

endmodule
`default_nettype wire
